operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Decode-to-execute operand stage directly downstream of the register file: drives the read
//  addresses, consumes the read data, applies EX/MEM/WB forwarding and holds the result in a
//  valid/ready pipeline register feeding execute.
//  Detects load-use hazards and stalls the upstream decode stage one cycle per hazard.
// PARAMETERS
//  DATA_WIDTH  32  operand / register width
//  ADDR_WIDTH  5   register index width (32 registers, r0 hardwired zero)
//  CNT_WIDTH   16  width of saturating stall counter
// PORTS
//  clk         in   1              rising-edge clock
//  rst         in   1              synchronous reset, active-low
//  in_valid    in   1              decode presents an instruction
//  in_ready    out  1              stage accepts this cycle
//  in_rs       in   ADDR_WIDTH     source A index
//  in_rt       in   ADDR_WIDTH     source B index
//  in_dst      in   ADDR_WIDTH     destination index (decode supplies 31 for jal)
//  in_wen      in   1              instruction writes in_dst
//  in_is_load  in   1              instruction is a load
//  rr          out  2*ADDR_WIDTH   to register file: {in_rt, in_rs}
//  q           in   2*DATA_WIDTH   from register file: {data_rt, data_rs}, async read
//  ex_wen, ex_is_load in 1; ex_dst in ADDR_WIDTH; ex_data in DATA_WIDTH   EX result bus
//  mem_wen     in 1; mem_dst in ADDR_WIDTH; mem_data in DATA_WIDTH        MEM result bus
//  wb_wen      in 1; wb_dst in ADDR_WIDTH; wb_data in DATA_WIDTH          WB bus (same as regfile wr/rw/d)
//  out_valid   out  1              execute register holds an instruction
//  out_ready   in   1              execute consumes this cycle
//  out_a, out_b       out DATA_WIDTH   resolved operands rs, rt
//  out_dst     out ADDR_WIDTH; out_wen, out_is_load out 1   forwarded control
//  stall_cnt   out  CNT_WIDTH      load-use stall cycles since reset, saturating
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): out_valid=0, out_a=out_b=0, out_dst=0, out_wen=0,
//    out_is_load=0, stall_cnt=0; in-flight instruction discarded. in_ready comb, follows below.
//  - rr = {in_rt, in_rs} combinationally, regardless of in_valid.
//  - Operand select per source s (rs or rt), priority order:
//    s==0 -> 0; ex_wen&&ex_dst==s&&!ex_is_load -> ex_data; mem_wen&&mem_dst==s -> mem_data;
//    wb_wen&&wb_dst==s -> wb_data; else q slice. Dst 0 never forwards.
//  - hazard = in_valid && ex_wen && ex_is_load && ex_dst!=0 && (ex_dst==in_rs || ex_dst==in_rt).
//  - in_ready = (!out_valid || out_ready) && !hazard.
//  - Accept (in_valid&&in_ready): next clk loads out_* from resolved operands/control, out_valid=1.
//  - Else if out_ready: out_valid=0 (bubble); out data regs hold stale value, don't-care.
//  - Else (out_valid&&!out_ready): all out_* hold; no new accept.
//  - Latency: accept at edge N -> out_valid at edge N+1; one instruction per cycle when unstalled.
//  - Stall: every cycle with hazard && (!out_valid||out_ready) increments stall_cnt;
//    saturates at all-ones. Back-pressure cycles are not counted.
//  - Hazard resolves when load moves to MEM; operand then forwarded from mem_data.
//  - Simultaneous EX/MEM/WB hits on same index: youngest (EX) wins.
// TESTING
//  - Reset: rst=0 two cycles with in_valid=1 -> out_valid=0, stall_cnt=0, outputs all zero.
//  - Plain read: regfile r3=0x11, r4=0x22, no forwarding, rs=3 rt=4 -> next cycle out_a=0x11 out_b=0x22.
//  - Priority: rs=5 with ex_data=0xA, mem_data=0xB, wb_data=0xC all targeting r5 -> out_a=0xA; rs=0 -> out_a=0.
//  - Load-use: ex load dst=7, in_rs=7 -> in_ready=0 one cycle, stall_cnt=1; next cycle mem_dst=7
//    mem_data=0x55 -> accept, out_a=0x55.
//  - Back-pressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable, in_ready=0, stall_cnt unchanged.
//  - Saturation: CNT_WIDTH=2, force 5 hazard cycles -> stall_cnt=3.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// Bus between decode, register file, the forwarding sources and the operand fetch stage.
//   master : decode / register file / pipeline side. Drives the instruction, q, the
//            EX/MEM/WB result buses and out_ready.
//   slave  : operand_fetch_stage. Drives in_ready, rr, the execute register outputs and
//            stall_cnt.
interface operand_fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
);
  // Decode side
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDR_WIDTH-1:0]   in_rs;
  logic [ADDR_WIDTH-1:0]   in_rt;
  logic [ADDR_WIDTH-1:0]   in_dst;
  logic                    in_wen;
  logic                    in_is_load;
  // Register file read port
  logic [2*ADDR_WIDTH-1:0] rr;
  logic [2*DATA_WIDTH-1:0] q;
  // Forwarding buses
  logic                    ex_wen;
  logic                    ex_is_load;
  logic [ADDR_WIDTH-1:0]   ex_dst;
  logic [DATA_WIDTH-1:0]   ex_data;
  logic                    mem_wen;
  logic [ADDR_WIDTH-1:0]   mem_dst;
  logic [DATA_WIDTH-1:0]   mem_data;
  logic                    wb_wen;
  logic [ADDR_WIDTH-1:0]   wb_dst;
  logic [DATA_WIDTH-1:0]   wb_data;
  // Execute side
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_a;
  logic [DATA_WIDTH-1:0]   out_b;
  logic [ADDR_WIDTH-1:0]   out_dst;
  logic                    out_wen;
  logic                    out_is_load;
  logic [CNT_WIDTH-1:0]    stall_cnt;

  modport master (
    output in_valid, in_rs, in_rt, in_dst, in_wen, in_is_load, q,
           ex_wen, ex_is_load, ex_dst, ex_data, mem_wen, mem_dst, mem_data,
           wb_wen, wb_dst, wb_data, out_ready,
    input  in_ready, rr, out_valid, out_a, out_b, out_dst, out_wen, out_is_load, stall_cnt
  );

  modport slave (
    input  in_valid, in_rs, in_rt, in_dst, in_wen, in_is_load, q,
           ex_wen, ex_is_load, ex_dst, ex_data, mem_wen, mem_dst, mem_data,
           wb_wen, wb_dst, wb_data, out_ready,
    output in_ready, rr, out_valid, out_a, out_b, out_dst, out_wen, out_is_load, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage between decode and execute.
// Drives the register-file read addresses, resolves both operands through EX/MEM/WB
// forwarding, and holds the result in a valid/ready register feeding execute. A load
// in EX whose destination is a source of the incoming instruction stalls decode until
// the load reaches MEM, where its data can be forwarded.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active-low
//   bus : operand_fetch_stage_if.slave (handshakes, regfile port, forwarding, outputs)
module operand_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  rst,
  operand_fetch_stage_if.slave bus
);

  // Forwarding priority: youngest producer first. r0 is hardwired zero, so a
  // destination of 0 can never match a non-zero source.
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic [ADDR_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  ex_wen,
    input logic                  ex_is_load,
    input logic [ADDR_WIDTH-1:0] ex_dst,
    input logic [DATA_WIDTH-1:0] ex_data,
    input logic                  mem_wen,
    input logic [ADDR_WIDTH-1:0] mem_dst,
    input logic [DATA_WIDTH-1:0] mem_data,
    input logic                  wb_wen,
    input logic [ADDR_WIDTH-1:0] wb_dst,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    if (src == '0)                                      return '0;
    // A load in EX has no data yet; the hazard logic stalls instead.
    else if (ex_wen && !ex_is_load && ex_dst == src)    return ex_data;
    else if (mem_wen && mem_dst == src)                 return mem_data;
    else if (wb_wen && wb_dst == src)                   return wb_data;
    else                                                return rf_data;
  endfunction

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
  logic [DATA_WIDTH-1:0] out_b_q, out_b_d;
  logic [ADDR_WIDTH-1:0] out_dst_q, out_dst_d;
  logic                  out_wen_q, out_wen_d;
  logic                  out_is_load_q, out_is_load_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic                  hazard;
  logic                  slot_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] a_sel, b_sel;

  assign bus.rr = {bus.in_rt, bus.in_rs};

  always_comb begin
    a_sel = resolve(bus.in_rs, bus.q[DATA_WIDTH-1:0],
                    bus.ex_wen, bus.ex_is_load, bus.ex_dst, bus.ex_data,
                    bus.mem_wen, bus.mem_dst, bus.mem_data,
                    bus.wb_wen, bus.wb_dst, bus.wb_data);
    b_sel = resolve(bus.in_rt, bus.q[2*DATA_WIDTH-1:DATA_WIDTH],
                    bus.ex_wen, bus.ex_is_load, bus.ex_dst, bus.ex_data,
                    bus.mem_wen, bus.mem_dst, bus.mem_data,
                    bus.wb_wen, bus.wb_dst, bus.wb_data);
  end

  assign hazard = bus.in_valid && bus.ex_wen && bus.ex_is_load && (bus.ex_dst != '0) &&
                  ((bus.ex_dst == bus.in_rs) || (bus.ex_dst == bus.in_rt));
  // The execute register can take a new entry when empty or draining this cycle.
  assign slot_free    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = slot_free && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path infers a latch.
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_dst_d     = out_dst_q;
    out_wen_d     = out_wen_q;
    out_is_load_d = out_is_load_q;
    stall_cnt_d   = stall_cnt_q;

    if (accept) begin
      out_valid_d   = 1'b1;
      out_a_d       = a_sel;
      out_b_d       = b_sel;
      out_dst_d     = bus.in_dst;
      out_wen_d     = bus.in_wen;
      out_is_load_d = bus.in_is_load;
    end else if (bus.out_ready) begin
      // Bubble: data registers keep stale contents, only valid drops.
      out_valid_d = 1'b0;
    end

    // Only stalls caused by the hazard count; back-pressure cycles do not.
    if (hazard && slot_free && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_dst_q     <= '0;
      out_wen_q     <= 1'b0;
      out_is_load_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_dst_q     <= out_dst_d;
      out_wen_q     <= out_wen_d;
      out_is_load_q <= out_is_load_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_a       = out_a_q;
  assign bus.out_b       = out_b_q;
  assign bus.out_dst     = out_dst_q;
  assign bus.out_wen     = out_wen_q;
  assign bus.out_is_load = out_is_load_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] rf [32];

  operand_fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
  operand_fetch_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2))  bus2 ();

  operand_fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  operand_fetch_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Register file model: asynchronous read driven by the stage's read addresses.
  assign bus.q  = {rf[bus.rr[9:5]], rf[bus.rr[4:0]]};
  assign bus2.q = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and registered outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_rs = 0; bus.in_rt = 0; bus.in_dst = 0;
    bus.in_wen = 0; bus.in_is_load = 0; bus.out_ready = 1;
    bus.ex_wen = 0; bus.ex_is_load = 0; bus.ex_dst = 0; bus.ex_data = 0;
    bus.mem_wen = 0; bus.mem_dst = 0; bus.mem_data = 0;
    bus.wb_wen = 0; bus.wb_dst = 0; bus.wb_data = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    idle_inputs();
    bus2.in_valid = 0; bus2.in_rs = 0; bus2.in_rt = 0; bus2.in_dst = 0;
    bus2.in_wen = 0; bus2.in_is_load = 0; bus2.out_ready = 1;
    bus2.ex_wen = 0; bus2.ex_is_load = 0; bus2.ex_dst = 0; bus2.ex_data = 0;
    bus2.mem_wen = 0; bus2.mem_dst = 0; bus2.mem_data = 0;
    bus2.wb_wen = 0; bus2.wb_dst = 0; bus2.wb_data = 0;
    rst = 0;
    bus.in_valid = 1; bus.in_rs = 5'd3; bus.in_rt = 5'd4; bus.in_dst = 5'd9;
    bus.in_wen = 1; bus.in_is_load = 1;
    step();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_a !== 32'h0 || bus.out_b !== 32'h0) begin n_fail++; $display("FAIL reset_operands: got %h/%h want 0/0", bus.out_a, bus.out_b); end
    n_checks++; if (bus.out_dst !== 5'd0 || bus.out_wen !== 1'b0 || bus.out_is_load !== 1'b0) begin
      n_fail++; $display("FAIL reset_control: got dst=%0d wen=%b ld=%b want 0/0/0", bus.out_dst, bus.out_wen, bus.out_is_load); end
    n_checks++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); end
    n_checks++; if (bus2.stall_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_stall_cnt_sat: got %0d want 0", bus2.stall_cnt); end
    n_checks++; if (bus.rr !== {5'd4, 5'd3}) begin n_fail++; $display("FAIL reset_rr: got %h want %h", bus.rr, {5'd4, 5'd3}); end
    idle_inputs();
    rst = 1;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_plain_read();
    rf[3] = 32'h11; rf[4] = 32'h22;
    bus.in_valid = 1; bus.in_rs = 5'd3; bus.in_rt = 5'd4; bus.in_dst = 5'd9;
    bus.in_wen = 1; bus.in_is_load = 0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL plain_in_ready: got %b want 1", bus.in_ready); end
    step();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL plain_out_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_a !== 32'h11 || bus.out_b !== 32'h22) begin n_fail++; $display("FAIL plain_operands: got %h/%h want 11/22", bus.out_a, bus.out_b); end
    n_checks++; if (bus.out_dst !== 5'd9 || bus.out_wen !== 1'b1 || bus.out_is_load !== 1'b0) begin
      n_fail++; $display("FAIL plain_control: got dst=%0d wen=%b ld=%b want 9/1/0", bus.out_dst, bus.out_wen, bus.out_is_load); end
    bus.in_valid = 0;
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL plain_bubble: got %b want 0", bus.out_valid); end
  endtask

  // Back-to-back accepts, each exercising one level of the forwarding priority.
  task automatic test_priority();
    rf[5] = 32'h55555555; rf[6] = 32'h66;
    bus.in_valid = 1; bus.in_rs = 5'd5; bus.in_rt = 5'd6; bus.in_dst = 5'd1; bus.in_wen = 1;
    bus.ex_wen = 1;  bus.ex_dst = 5'd5;  bus.ex_data = 32'hA;
    bus.mem_wen = 1; bus.mem_dst = 5'd5; bus.mem_data = 32'hB;
    bus.wb_wen = 1;  bus.wb_dst = 5'd5;  bus.wb_data = 32'hC;
    step();
    n_checks++; if (bus.out_a !== 32'hA || bus.out_b !== 32'h66) begin n_fail++; $display("FAIL prio_ex: got %h/%h want a/66", bus.out_a, bus.out_b); end
    bus.ex_wen = 0;
    step();
    n_checks++; if (bus.out_a !== 32'hB || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL prio_mem: got a=%h v=%b want b/1", bus.out_a, bus.out_valid); end
    bus.mem_wen = 0;
    step();
    n_checks++; if (bus.out_a !== 32'hC) begin n_fail++; $display("FAIL prio_wb: got %h want c", bus.out_a); end
    bus.wb_dst = 5'd6; bus.wb_data = 32'h77;
    step();
    n_checks++; if (bus.out_a !== 32'h55555555 || bus.out_b !== 32'h77) begin n_fail++; $display("FAIL prio_rf_and_wb_rt: got %h/%h want 55555555/77", bus.out_a, bus.out_b); end
    bus.in_rs = 5'd0; bus.ex_wen = 1; bus.ex_dst = 5'd0; bus.ex_data = 32'hA;
    bus.mem_wen = 1; bus.mem_dst = 5'd0; bus.wb_dst = 5'd0;
    step();
    n_checks++; if (bus.out_a !== 32'h0) begin n_fail++; $display("FAIL prio_r0: got %h want 0", bus.out_a); end
    idle_inputs();
    step();
  endtask

  task automatic test_load_use();
    bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_dst = 5'd7; bus.ex_data = 32'hDEAD;
    bus.in_valid = 1; bus.in_rs = 5'd7; bus.in_rt = 5'd0; bus.in_dst = 5'd2; bus.in_wen = 1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_in_ready: got %b want 0", bus.in_ready); end
    step();
    n_checks++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL loaduse_stall_cnt: got %0d want 1", bus.stall_cnt); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_bubble: got %b want 0", bus.out_valid); end
    bus.ex_wen = 0; bus.ex_is_load = 0;
    bus.mem_wen = 1; bus.mem_dst = 5'd7; bus.mem_data = 32'h55;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL loaduse_resolved_ready: got %b want 1", bus.in_ready); end
    step();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h55) begin n_fail++; $display("FAIL loaduse_forward: got v=%b a=%h want 1/55", bus.out_valid, bus.out_a); end
    n_checks++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL loaduse_cnt_hold: got %0d want 1", bus.stall_cnt); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_pressure();
    bus.in_valid = 1; bus.in_rs = 5'd3; bus.in_rt = 5'd4; bus.in_dst = 5'd8; bus.in_wen = 1;
    step();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h11) begin n_fail++; $display("FAIL bp_load: got v=%b a=%h want 1/11", bus.out_valid, bus.out_a); end
    // Execute stalls while a load-use hazard is also pending: must not be counted.
    bus.out_ready = 0;
    bus.in_rs = 5'd4; bus.in_rt = 5'd3; bus.in_dst = 5'd10;
    bus.ex_wen = 1; bus.ex_is_load = 1; bus.ex_dst = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      step();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h11 || bus.out_b !== 32'h22 || bus.out_dst !== 5'd8) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b a=%h b=%h dst=%0d want 1/11/22/8", i, bus.out_valid, bus.out_a, bus.out_b, bus.out_dst); end
      n_checks++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_stall_cnt[%0d]: got %0d want 1", i, bus.stall_cnt); end
    end
    idle_inputs();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    bus2.out_ready = 1;
    bus2.in_valid = 1; bus2.in_rs = 5'd1; bus2.in_rt = 5'd2;
    bus2.ex_wen = 1; bus2.ex_is_load = 1; bus2.ex_dst = 5'd1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      n_checks++; if (bus2.stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus2.stall_cnt, exp_cnt); end
    end
    n_checks++; if (bus2.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_no_accept: got %b want 0", bus2.out_valid); end
    bus2.in_valid = 0; bus2.ex_wen = 0; bus2.ex_is_load = 0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 0;
    test_reset();
    test_plain_read();
    test_priority();
    test_load_use();
    test_back_pressure();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
